// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : Multi-cycle WIDTH-bit adder/subtractor that processes DIGIT bits
//            per clock. Subtraction is performed as A + ~B + ~borrow, so the
//            same digit adder serves both operations. A start/busy/done
//            handshake lets several requesters share one small adder.
// Revision : 1.0 - initial release
//
// Ports
//   clk    in   clock, all state updates on the rising edge
//   rst    in   asynchronous active-low reset
//   start  in   operation request, accepted when busy=0 (IDLE or DONE)
//   sub    in   0 = add, 1 = subtract (sampled with start)
//   a      in   operand A (sampled with start)
//   b      in   operand B (sampled with start)
//   cin    in   carry-in for add, borrow-in for subtract (sampled with start)
//   busy   out  high while digits are being processed
//   done   out  one-cycle pulse, s/cout/ovf have just been updated
//   s      out  result, modulo 2^WIDTH
//   cout   out  carry out of the MSB of the internal adder (sub: 1 = no borrow)
//   ovf    out  two's-complement overflow
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  // Number of digit steps per operation and the width of the digit counter.
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

  // Operands must split into a whole number of digits.
  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_adder: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)",
           WIDTH, DIGIT);
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // operand A, shifted right one digit per step
  logic [WIDTH-1:0] b_q, b_d;       // effective operand B' (inverted for subtract)
  logic             c_q, c_d;       // running carry between digits
  logic [WIDTH-1:0] acc_q, acc_d;   // partial sum, filled from the top
  logic [CW-1:0]    cnt_q, cnt_d;   // index of the digit being processed
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // --------------------------------------------------------------------------
  // Digit datapath
  // --------------------------------------------------------------------------
  logic [DIGIT:0]   dsum_w;         // DIGIT-bit sum plus carry out of the digit
  logic             cmsb_w;         // carry into the top bit of the digit
  logic [WIDTH-1:0] acc_shift_w;    // accumulator after inserting this digit

  assign dsum_w = {1'b0, a_q[DIGIT-1:0]}
                + {1'b0, b_q[DIGIT-1:0]}
                + {{DIGIT{1'b0}}, c_q};

  // sum = a ^ b ^ carry_in at any bit position, so the carry into the top bit
  // of the digit can be recovered without a second, narrower adder. On the
  // final digit this is the carry into the operand MSB needed for overflow.
  assign cmsb_w = dsum_w[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

  // New digit enters at the top; after N steps digit 0 sits at the bottom.
  assign acc_shift_w = (acc_q >> DIGIT)
                     | (WIDTH'(dsum_w[DIGIT-1:0]) << (WIDTH - DIGIT));

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtract: a - b - borrow == a + ~b + ~borrow.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          c_d     = cin ^ sub;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = dsum_w[DIGIT];
        acc_d = acc_shift_w;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_DIGIT) begin
          s_d     = acc_shift_w;
          cout_d  = dsum_w[DIGIT];
          ovf_d   = cmsb_w ^ dsum_w[DIGIT];
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are registered from the next state so that they
    // carry no combinational path from the inputs.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: doc/serial_adder.md
# serial_adder

Multi-cycle, parametrised integer adder/subtractor for the MIPS datapath. It generalises the single-bit full adder to a WIDTH-bit operand, processed DIGIT bits per clock. It supports add and subtract with carry/borrow-in and reports carry-out and signed overflow. A start/busy/done handshake lets a multi-cycle ALU path or the testbench sequencer share one small adder.

## Interface
- WIDTH, 32, operand/result width in bits; WIDTH % DIGIT == 0 or elaboration fails ($error)
- DIGIT, 1, bits added per clock; N = WIDTH/DIGIT cycles per operation
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk)
- start  in  1  request; accepted on a rising edge when busy=0
- sub  in  1  0 = add, 1 = subtract; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- cin  in  1  carry-in (add) / borrow-in (sub); sampled with start
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse: s/cout/ovf just updated
- s  out  WIDTH  result
- cout  out  1  carry out of bit WIDTH-1 of the internal adder
- ovf  out  1  two's-complement overflow (carry into MSB XOR carry out of MSB)

## Operation
- Effective operands: B' = b ^ {WIDTH{sub}}, c0 = cin ^ sub. Add: s = a + b + cin. Sub: s = a - b - cin (cin=1 means borrow-in); cout=1 means no borrow.
- FSM states IDLE, RUN, DONE; reset state IDLE.
- IDLE: busy=0, done=0. On edge with start=1: latch a, B', c0 into internal shift registers, clear digit counter, go to RUN.
- RUN: busy=1. Each edge adds the low DIGIT bits of A and B' plus the carry register, shifts the DIGIT-bit sum into the internal result shift register from the top, shifts A/B' right by DIGIT, and updates carry. Input pins are ignored; start is not accepted.
- On the edge processing digit N-1: transfer the full sum to s, final carry to cout, and (carry into MSB) ^ (carry out of MSB) to ovf; go to DONE.
- DONE: done=1, busy=0. start=1 on this edge is accepted (back-to-back: latch, go to RUN). Otherwise go to IDLE.
- s, cout and ovf change only on the edge entering DONE, or on reset. They hold their value through IDLE and the next RUN.
- Arithmetic is modulo 2^WIDTH. Counter width is $clog2(N) (minimum 1). WIDTH=DIGIT gives N=1, a single-cycle RUN.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0, and all internal registers 0. Reset during RUN aborts the operation: no done pulse and no result update.
- Release rst synchronously to clk. The first start is accepted on the first rising edge with rst=1.
- Latency: start accepted at edge k; busy=1 for the cycles after edges k..k+N-1; the result registers and done=1 appear after edge k+N; done drops after edge k+N+1.
- Throughput: one result per N+1 cycles with start held high, or N+1 cycles back-to-back via DONE acceptance.
- start asserted during RUN is ignored and not queued. It is accepted only when it is still high at an edge in IDLE or DONE.
- busy and done are never high together; both are registered outputs with no combinational path from inputs.

## Test plan
Tests use WIDTH=8, DIGIT=2 (N=4) unless stated.
- a=0x7F, b=0x01, cin=0, sub=0 -> after 4 edges s=0x80, cout=0, ovf=1, done high exactly 1 cycle, busy high exactly 4 cycles.
- a=0x10, b=0x20, cin=0, sub=1 -> s=0xF0, cout=0 (borrow), ovf=0; then a=0x20, b=0x10, sub=1, cin=1 -> s=0x0F, cout=1, ovf=0.
- a=0xFF, b=0x01, cin=1, sub=0 -> s=0x01, cout=1, ovf=0; a and b toggled randomly during RUN must not affect the result.
- start held high continuously from reset release with alternating operand sets -> results every 5 cycles, each matching its own operands; pulses of start during RUN produce no extra done.
- rst driven low asynchronously (mid-clock) on the 2nd RUN cycle -> busy, done, s, cout, ovf go to 0 immediately; no done after release; the next operation is correct.
- WIDTH=4, DIGIT=1 and WIDTH=4, DIGIT=4: exhaustive a, b, cin, sub (1024 vectors) read via $readmemb from a vector file, compared at negedge after done -> 0 mismatches; the error count and vector count are printed before $stop.
